instr_fetch: RTL and testbench

- Fetch stage that drives the instruction register's load interface: supplies the 16-bit instruction word plus a load enable.
- Holds a word-addressed PC and issues in-order reads to instruction memory with variable latency.
- Buffers returned words in a small prefetch queue.
- Replays an instruction squashed by a hazard; flushes and redirects on a taken branch.

---
 rtl/instr_fetch.sv | 121 ++++++++++++
 tb/tb_instr_fetch.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: in-order prefetch from a variable-latency instruction
// memory into a small buffer that feeds the IR load interface.
module instr_fetch #(
    parameter int          ADDR_W   = 8,
    parameter int          DEPTH    = 2,
    parameter logic [15:0] NOP_WORD = 16'hC000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_valid,
    input  logic              hazard,
    input  logic              branch,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [15:0]       mem_data,
    output logic              IRin,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] fetch_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]                 count_q, count_d;
    logic [CW-1:0]                 outstanding_q, outstanding_d;
    logic [CW-1:0]                 drop_cnt_q, drop_cnt_d;
    logic [ADDR_W-1:0]             fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]             ret_pc_q, ret_pc_d;
    logic                          irin_q, irin_d;
    logic [DEPTH-1:0][15:0]        buf_data_q, buf_data_d;
    logic [DEPTH-1:0][ADDR_W-1:0]  buf_pc_q, buf_pc_d;

    logic          issue, pop, push, drop;
    logic [CW:0]   in_use;

    always_comb begin
        in_use = {1'b0, count_q} + {1'b0, outstanding_q};
        // Buffered plus in-flight words never exceed DEPTH, so a push can't overflow.
        issue  = !rst && !branch && (in_use < (CW+1)'(DEPTH));
        pop    = irin_q && (count_q != '0) && !hazard && !branch;
        drop   = imem_valid && (drop_cnt_q != '0);
        push   = imem_valid && !drop && !branch;

        fetch_pc_d    = fetch_pc_q;
        ret_pc_d      = ret_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        buf_data_d    = buf_data_q;
        buf_pc_d      = buf_pc_q;
        irin_d        = 1'b1;

        if (issue) begin
            fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
            outstanding_d = outstanding_d + CW'(1);
        end
        if (imem_valid)
            outstanding_d = outstanding_d - CW'(1);
        if (drop)
            drop_cnt_d = drop_cnt_q - CW'(1);

        // Head always sits in slot 0; a pop shifts the rest down.
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                buf_data_d[i] = buf_data_q[i+1];
                buf_pc_d[i]   = buf_pc_q[i+1];
            end
            count_d = count_q - CW'(1);
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == count_d) begin
                    buf_data_d[i] = imem_rdata;
                    buf_pc_d[i]   = ret_pc_q;
                end
            end
            count_d  = count_d + CW'(1);
            ret_pc_d = ret_pc_q + ADDR_W'(1);
        end

        // Everything still owed by memory belongs to the abandoned stream.
        if (branch) begin
            count_d    = '0;
            fetch_pc_d = branch_target;
            ret_pc_d   = branch_target;
            drop_cnt_d = outstanding_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q       <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            fetch_pc_q    <= '0;
            ret_pc_q      <= '0;
            irin_q        <= 1'b0;
        end else begin
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            fetch_pc_q    <= fetch_pc_d;
            ret_pc_q      <= ret_pc_d;
            irin_q        <= irin_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_data_q <= buf_data_d;
        buf_pc_q   <= buf_pc_d;
    end

    assign imem_req  = issue;
    assign imem_addr = fetch_pc_q;
    assign fetch_pc  = fetch_pc_q;
    assign IRin      = irin_q;
    assign mem_data  = (count_q != '0) ? buf_data_q[0] : NOP_WORD;
    assign instr_pc  = (count_q != '0) ? buf_pc_q[0] : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed table, hand-written corner sequences and a
// randomized run against a queue-based reference model and a latency-driven memory.
module tb_instr_fetch;

    localparam int          DEPTH = 2;
    localparam logic [15:0] NOP   = 16'hC000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata = 16'h0;
    logic        imem_valid = 1'b0;
    logic        hazard = 1'b0;
    logic        branch = 1'b0;
    logic [7:0]  branch_target = 8'h0;
    logic [15:0] mem_data;
    logic        IRin;
    logic [7:0]  instr_pc;
    logic [7:0]  fetch_pc;

    instr_fetch #(.ADDR_W(8), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .hazard(hazard), .branch(branch), .branch_target(branch_target),
        .mem_data(mem_data), .IRin(IRin), .instr_pc(instr_pc), .fetch_pc(fetch_pc)
    );

    always #5 clk = ~clk;

    // Memory: one response per cycle, in order, at least lat cycles after the request.
    typedef struct { logic [7:0] addr; int due; } mreq_t;
    mreq_t mq[$];
    int    last_due = 0;
    int    lat = 1;
    int    cyc = 0;

    // Reference model: words in flight tagged live/dead, buffered words with their address.
    typedef struct { logic [7:0] addr; bit live; } fly_t;
    typedef struct { logic [15:0] word; logic [7:0] pc; } ent_t;
    fly_t       fq[$];
    ent_t       bq[$];
    logic [7:0] m_pc = 8'h0;
    bit         m_irin = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    bit en_chk   = 1'b0;

    logic [15:0] cap_data;
    logic [7:0]  cap_pc, cap_addr, cap_fpc;
    logic        cap_irin, cap_req;

    logic [15:0] wq[$];
    logic [7:0]  aq[$];
    logic [15:0] rec_first_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input logic r, input logic h, input logic b, input logic [7:0] t);
        logic [15:0] e_data;
        logic        e_req;
        bit          mem_resp;
        bit          do_pop;
        bit          got;
        fly_t        f;
        int          due;
        @(negedge clk);
        rst = r; hazard = h; branch = b; branch_target = t;
        mem_resp = 1'b0; imem_valid = 1'b0; imem_rdata = 16'h0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            mem_resp   = 1'b1;
            imem_valid = 1'b1;
            imem_rdata = 16'h1000 + {8'h00, mq[0].addr};
        end else if (r && ($urandom_range(0, 3) == 0)) begin
            imem_valid = 1'b1;
            imem_rdata = 16'hBAD0;
        end
        #1;
        e_req  = !r && !b && (bq.size() + fq.size() < DEPTH);
        e_data = (bq.size() > 0) ? bq[0].word : NOP;
        cap_data = mem_data; cap_pc = instr_pc; cap_irin = IRin;
        cap_req = imem_req; cap_addr = imem_addr; cap_fpc = fetch_pc;
        if (en_chk) begin
            chk("mem_data", {16'h0, cap_data}, {16'h0, e_data});
            chk("IRin", {31'h0, cap_irin}, {31'h0, m_irin});
            chk("imem_req", {31'h0, cap_req}, {31'h0, e_req});
            chk("fetch_pc", {24'h0, cap_fpc}, {24'h0, m_pc});
            if (e_req) chk("imem_addr", {24'h0, cap_addr}, {24'h0, m_pc});
            if (bq.size() > 0) chk("instr_pc", {24'h0, cap_pc}, {24'h0, bq[0].pc});
        end
        @(posedge clk);
        if (r) begin
            bq.delete(); fq.delete(); m_pc = 8'h0; m_irin = 1'b0;
        end else begin
            got = 1'b0;
            if (imem_valid) begin
                chk("valid_owed", {31'h0, fq.size() > 0}, 32'h1);
                if (fq.size() > 0) begin f = fq.pop_front(); got = 1'b1; end
            end
            if (b) begin
                bq.delete();
                foreach (fq[i]) fq[i].live = 1'b0;
                m_pc = t;
            end else begin
                do_pop = m_irin && bq.size() > 0 && !h;
                if (do_pop) void'(bq.pop_front());
                if (got && f.live) bq.push_back('{imem_rdata, f.addr});
                if (e_req) begin fq.push_back('{m_pc, 1'b1}); m_pc = m_pc + 8'h1; end
            end
            m_irin = 1'b1;
        end
        if (r) begin
            mq.delete(); last_due = 0;
        end else begin
            if (mem_resp) void'(mq.pop_front());
            if (cap_req) begin
                due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                mq.push_back('{cap_addr, due});
                last_due = due;
            end
        end
        cyc++;
    endtask

    // Run n plain cycles, logging consumed words and requested addresses.
    task automatic run_rec(input int n);
        wq.delete(); aq.delete();
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            if (i == 0) rec_first_data = cap_data;
            if (cap_irin && cap_data !== NOP) wq.push_back(cap_data);
            if (cap_req) aq.push_back(cap_addr);
        end
    endtask

    function automatic logic [31:0] wat(input int i);
        return (wq.size() > i) ? {16'h0, wq[i]} : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] aat(input int i);
        return (aq.size() > i) ? {24'h0, aq[i]} : 32'hFFFF_FFFF;
    endfunction

    typedef struct {
        logic rst; logic haz;
        logic [15:0] data; logic [7:0] pc; logic irin; logic req; logic [7:0] addr;
    } vec_t;
    vec_t tbl[12];

    task automatic setv(input int i, input logic r, input logic h, input logic [15:0] d,
                        input logic [7:0] p, input logic ir, input logic rq, input logic [7:0] a);
        tbl[i] = '{r, h, d, p, ir, rq, a};
    endtask

    initial begin
        // Latency-1 stream from reset with a two-cycle hazard on word 0x1003.
        setv(0,  1'b1, 1'b0, 16'hC000, 8'h00, 1'b0, 1'b0, 8'h00);
        setv(1,  1'b0, 1'b0, 16'hC000, 8'h00, 1'b0, 1'b1, 8'h00);
        setv(2,  1'b0, 1'b0, 16'hC000, 8'h00, 1'b1, 1'b1, 8'h01);
        setv(3,  1'b0, 1'b0, 16'h1000, 8'h00, 1'b1, 1'b0, 8'h00);
        setv(4,  1'b0, 1'b0, 16'h1001, 8'h01, 1'b1, 1'b1, 8'h02);
        setv(5,  1'b0, 1'b0, 16'hC000, 8'h00, 1'b1, 1'b1, 8'h03);
        setv(6,  1'b0, 1'b0, 16'h1002, 8'h02, 1'b1, 1'b0, 8'h00);
        setv(7,  1'b0, 1'b1, 16'h1003, 8'h03, 1'b1, 1'b1, 8'h04);
        setv(8,  1'b0, 1'b1, 16'h1003, 8'h03, 1'b1, 1'b0, 8'h00);
        setv(9,  1'b0, 1'b0, 16'h1003, 8'h03, 1'b1, 1'b0, 8'h00);
        setv(10, 1'b0, 1'b0, 16'h1004, 8'h04, 1'b1, 1'b1, 8'h05);
        setv(11, 1'b0, 1'b0, 16'hC000, 8'h00, 1'b1, 1'b1, 8'h06);

        lat = 1;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        en_chk = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].haz, 1'b0, 8'h00);
            chk($sformatf("tbl%0d_data", i), {16'h0, cap_data}, {16'h0, tbl[i].data});
            chk($sformatf("tbl%0d_irin", i), {31'h0, cap_irin}, {31'h0, tbl[i].irin});
            chk($sformatf("tbl%0d_req", i), {31'h0, cap_req}, {31'h0, tbl[i].req});
            if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), {24'h0, cap_addr}, {24'h0, tbl[i].addr});
            if (tbl[i].data !== NOP) chk($sformatf("tbl%0d_pc", i), {24'h0, cap_pc}, {24'h0, tbl[i].pc});
        end

        // Branch to 0x40 with two latency-3 reads outstanding.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        lat = 3;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h40);
        run_rec(14);
        chk("br40_first_nop", {16'h0, rec_first_data}, {16'h0, NOP});
        chk("br40_word0", wat(0), 32'h1040);
        chk("br40_word1", wat(1), 32'h1041);
        chk("br40_addr0", aat(0), 32'h40);
        chk("br40_addr1", aat(1), 32'h41);

        // Branch and hazard together behave as branch alone.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        lat = 1;
        run_rec(6);
        step(1'b0, 1'b1, 1'b1, 8'h10);
        run_rec(8);
        chk("brhz_first_nop", {16'h0, rec_first_data}, {16'h0, NOP});
        chk("brhz_word0", wat(0), 32'h1010);
        chk("brhz_word1", wat(1), 32'h1011);

        // Branch near the top of the address space: fetch wraps to 0.
        step(1'b0, 1'b0, 1'b1, 8'hFE);
        run_rec(10);
        chk("wrap_word0", wat(0), 32'h10FE);
        chk("wrap_word1", wat(1), 32'h10FF);
        chk("wrap_word2", wat(2), 32'h1000);
        chk("wrap_addr2", aat(2), 32'h00);

        // Reset pulse with a full buffer held by a long hazard.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        lat = 1;
        run_rec(3);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("full_issue_stopped", {31'h0, cap_req}, 32'h0);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("rst_data_nop", {16'h0, cap_data}, {16'h0, NOP});
        chk("rst_irin", {31'h0, cap_irin}, 32'h0);
        chk("rst_fetch_pc", {24'h0, cap_fpc}, 32'h0);
        chk("rst_req", {31'h0, cap_req}, 32'h1);
        chk("rst_addr", {24'h0, cap_addr}, 32'h0);

        // Randomized run: hazards, branches, latency changes and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) lat = $urandom_range(1, 4);
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 8),
                 8'($urandom_range(0, 255)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
